// File: rtl/adder_seq_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq_arbiter_if
// Brief    : Request/response bundle for the shared multi-precision adder.
// Revision : 1.0 - initial release
// ============================================================================
interface adder_seq_arbiter_if #(
    parameter int WIDTH  = 4,
    parameter int NWORDS = 4
);
    localparam int TW = NWORDS * (WIDTH + 1);

    logic          req0_valid;
    logic          req0_ready;
    logic [TW-1:0] req0_a;
    logic [TW-1:0] req0_b;
    logic          req0_cin;

    logic          req1_valid;
    logic          req1_ready;
    logic [TW-1:0] req1_a;
    logic [TW-1:0] req1_b;
    logic          req1_cin;

    logic          resp_valid;
    logic          resp_ready;
    logic          resp_id;
    logic [TW-1:0] resp_sum;
    logic          resp_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_sum, resp_cout
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_sum, resp_cout
    );
endinterface
`default_nettype wire

// File: rtl/varAdder.sv
`default_nettype none
// ============================================================================
// Module   : varAdder
// Brief    : (WIDTH+1)-bit ripple adder with carry-in and signed overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module varAdder #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH:0] A,
    input  wire logic [WIDTH:0] B,
    input  wire logic           Cin,
    output logic      [WIDTH:0] Sum,
    output logic                Overflow
);
    assign Sum      = A + B + {{WIDTH{1'b0}}, Cin};
    assign Overflow = (A[WIDTH] == B[WIDTH]) && (Sum[WIDTH] != A[WIDTH]);
endmodule
`default_nettype wire

// File: rtl/adder_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq_arbiter
// Brief    : Round-robin scheduler sharing one word-serial adder between two
//            requesters. Define ADDSEQ_SAT_EN for unsigned saturation.
// Revision : 1.0 - initial release
// ============================================================================
module adder_seq_arbiter #(
    parameter int WIDTH  = 4,
    parameter int NWORDS = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    adder_seq_arbiter_if.slave bus,
    output logic               busy
);
    localparam int TW = NWORDS * (WIDTH + 1);
    localparam int WW = WIDTH + 1;
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic          r_last_grant;
    logic          r_id;
    logic [TW-1:0] r_a;
    logic [TW-1:0] r_b;
    logic [TW-1:0] r_sum;
    logic          r_carry;
    logic [KW-1:0] r_k;

    logic          w_grant;
    logic          w_accept;
    logic [WW:0]   w_op_a;
    logic [WW:0]   w_op_b;
    logic [WW:0]   w_word;
    logic          w_unused_ovf;
    logic [TW-1:0] w_sum_out;

    // With both valid, the requester that did not win last time is served.
    assign w_grant  = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    assign w_accept = (r_state == S_IDLE) && (bus.req0_valid || bus.req1_valid);

    assign w_op_a = {1'b0, r_a[r_k*WW +: WW]};
    assign w_op_b = {1'b0, r_b[r_k*WW +: WW]};

    varAdder #(.WIDTH(WIDTH + 1)) u_adder (
        .A        (w_op_a),
        .B        (w_op_b),
        .Cin      (r_carry),
        .Sum      (w_word),
        .Overflow (w_unused_ovf)
    );

`ifdef ADDSEQ_SAT_EN
    assign w_sum_out = r_carry ? {TW{1'b1}} : r_sum;
`else
    assign w_sum_out = r_sum;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_RUN;
            S_RUN:   if (r_k == K_LAST) w_next_state = S_DONE;
            S_DONE:  if (bus.resp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_id    = 1'b0;
        bus.resp_sum   = '0;
        bus.resp_cout  = 1'b0;
        busy           = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req0_ready = bus.req0_valid && !w_grant;
                bus.req1_ready = bus.req1_valid && w_grant;
            end
            S_RUN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy           = 1'b1;
                bus.resp_valid = 1'b1;
                bus.resp_id    = r_id;
                bus.resp_sum   = w_sum_out;
                bus.resp_cout  = r_carry;
            end
            default: ;
        endcase
    end

    // Operand capture and word-serial accumulation; the carry register doubles as cin.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_k          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_grant ? bus.req1_a   : bus.req0_a;
                        r_b          <= w_grant ? bus.req1_b   : bus.req0_b;
                        r_carry      <= w_grant ? bus.req1_cin : bus.req0_cin;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_sum        <= '0;
                        r_k          <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[r_k*WW +: WW] <= w_word[WW-1:0];
                    r_carry             <= w_word[WW];
                    if (r_k != K_LAST) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
